lzd_norm_ctrl: RTL

//  Normalization control stage after the significand adder. Latches the raw add/sub result
//  and exponent, then finds the leading one or the carry-out. Produces shift amount,

---
 rtl/fpu_norm_pkg.sv | 19 +
 rtl/lzd_norm_ctrl_if.sv | 36 +++
 rtl/lzc_group4.sv | 22 ++
 rtl/lzd_norm_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fpu_norm_pkg.sv
// Shared constants for the normalization control stage: default widths,
// leading-zero group width, FSM state encoding and a group-count helper.
package fpu_norm_pkg;

  localparam int SW_DEF = 26;
  localparam int EW_DEF = 8;
  localparam int GW     = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LATCH  = 2'd1;
  localparam logic [1:0] ST_DETECT = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Number of GW-bit groups needed to cover bits SW-2..0 (rounded up).
  function automatic int num_groups(input int sw);
    return (sw - 1 + GW - 1) / GW;
  endfunction

endpackage

// File: rtl/lzd_norm_ctrl_if.sv
// Bus between the normalization control stage and its producer/consumer.
// Handshake: the producer raises load_i while the stage is idle (busy_o low),
// holding Add_Subt_i/Exp_i valid for that cycle. The stage raises ready_o when
// results are valid and holds them unchanged until it samples ack_i high;
// ready_o drops on the edge after ack_i. load_i outside idle and ack_i outside
// the ready phase are ignored. state mirrors the FSM for observation.
interface lzd_norm_ctrl_if #(
  parameter int SW = 26,
  parameter int EW = 8
);
  logic          load_i;
  logic [SW-1:0] Add_Subt_i;
  logic [EW-1:0] Exp_i;
  logic          ack_i;
  logic          busy_o;
  logic          ready_o;
  logic [EW-1:0] Shift_Value_o;
  logic          left_right_o;
  logic [EW-1:0] Exp_adj_o;
  logic          zero_flag_o;
  logic          overflow_o;
  logic          underflow_o;
  logic [1:0]    state;

  modport master (
    output load_i, Add_Subt_i, Exp_i, ack_i,
    input  busy_o, ready_o, Shift_Value_o, left_right_o, Exp_adj_o,
           zero_flag_o, overflow_o, underflow_o, state
  );

  modport slave (
    input  load_i, Add_Subt_i, Exp_i, ack_i,
    output busy_o, ready_o, Shift_Value_o, left_right_o, Exp_adj_o,
           zero_flag_o, overflow_o, underflow_o, state
  );
endinterface

// File: rtl/lzc_group4.sv
// Combinational leading-zero count of a 4-bit group plus all-zero flag.
// An all-zero group reports a count of 4.
module lzc_group4 (
  input  logic [3:0] din,
  output logic [2:0] cnt,
  output logic       all_zero
);

  // Priority encode from the MSB of the group.
  always_comb begin
    cnt      = 3'd4;
    all_zero = (din == 4'b0000);
    casez (din)
      4'b1???: cnt = 3'd0;
      4'b01??: cnt = 3'd1;
      4'b001?: cnt = 3'd2;
      4'b0001: cnt = 3'd3;
      default: cnt = 3'd4;
    endcase
  end

endmodule

// File: rtl/lzd_norm_ctrl.sv
// Normalization control: latches the raw significand sum and exponent,
// finds the carry-out or the leading one, and produces the barrel-shifter
// shift amount/direction and the adjusted exponent with range flags.
module lzd_norm_ctrl
  import fpu_norm_pkg::*;
#(
  parameter int SW = SW_DEF,
  parameter int EW = EW_DEF
) (
  input logic              clk,
  input logic              rst,
  lzd_norm_ctrl_if.slave   bus
);

  localparam int NG   = num_groups(SW);
  localparam int PADW = NG * GW;

  logic [1:0]    state_q;
  logic [SW-1:0] sig_q;
  logic [EW-1:0] exp_q;
  logic [2:0]    grp_cnt_c  [NG];
  logic [2:0]    grp_cnt_q  [NG];
  logic [NG-1:0] grp_zero_c;
  logic [NG-1:0] grp_zero_q;
  logic [PADW-1:0] padded;

  logic [EW-1:0] lz_c;
  logic          found_c;
  logic [EW:0]   inc_c;
  logic [EW:0]   dec_c;

  logic [EW-1:0] r_shift, r_exp;
  logic          r_lr, r_z, r_ov, r_un;
  logic [EW-1:0] shift_q, exp_adj_q;
  logic          lr_q, z_q, ov_q, un_q;

  // Bits SW-2..0 left-aligned; unused low positions padded with ones so the
  // last group always holds a one and the count never runs past SW-2.
  always_comb begin
    padded = '1;
    padded[PADW-1 -: SW-1] = sig_q[SW-2:0];
  end

  // Group 0 is the most significant group.
  for (genvar g = 0; g < NG; g++) begin : g_lzc
    lzc_group4 u_lzc (
      .din      (padded[PADW-1-g*GW -: GW]),
      .cnt      (grp_cnt_c[g]),
      .all_zero (grp_zero_c[g])
    );
  end

  // Combine registered groups: first non-zero group wins.
  always_comb begin
    lz_c    = '0;
    found_c = 1'b0;
    for (int g = 0; g < NG; g++) begin
      if (!found_c && !grp_zero_q[g]) begin
        lz_c    = EW'(g * GW) + EW'(grp_cnt_q[g]);
        found_c = 1'b1;
      end
    end
  end

  assign inc_c = {1'b0, exp_q} + {{EW{1'b0}}, 1'b1};
  assign dec_c = {1'b0, exp_q} - {1'b0, lz_c};

  // Result priority: carry-out, then zero, then underflow, then normal shift.
  always_comb begin
    r_shift = '0;
    r_exp   = '0;
    r_lr    = 1'b1;
    r_z     = 1'b0;
    r_ov    = 1'b0;
    r_un    = 1'b0;
    if (sig_q[SW-1]) begin
      r_lr    = 1'b0;
      r_shift = EW'(1);
      if (inc_c[EW] || (&inc_c[EW-1:0])) begin
        r_ov  = 1'b1;
        r_exp = '1;
      end else begin
        r_exp = inc_c[EW-1:0];
      end
    end else if (sig_q[SW-2:0] == '0) begin
      r_z = 1'b1;
    end else if (dec_c[EW]) begin
      r_un    = 1'b1;
      r_shift = exp_q;
    end else begin
      r_shift = lz_c;
      r_exp   = dec_c[EW-1:0];
    end
  end

  // FSM: IDLE -> LATCH -> DETECT -> DONE -> IDLE on ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (bus.load_i) state_q <= ST_LATCH;
        ST_LATCH:  state_q <= ST_DETECT;
        ST_DETECT: state_q <= ST_DONE;
        ST_DONE:   if (bus.ack_i) state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  // Datapath registers: input latch, group register, result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q      <= '0;
      exp_q      <= '0;
      grp_zero_q <= '0;
      for (int g = 0; g < NG; g++) grp_cnt_q[g] <= '0;
      shift_q    <= '0;
      exp_adj_q  <= '0;
      lr_q       <= 1'b0;
      z_q        <= 1'b0;
      ov_q       <= 1'b0;
      un_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.load_i) begin
            sig_q <= bus.Add_Subt_i;
            exp_q <= bus.Exp_i;
          end
        end
        ST_LATCH: begin
          grp_zero_q <= grp_zero_c;
          for (int g = 0; g < NG; g++) grp_cnt_q[g] <= grp_cnt_c[g];
        end
        ST_DETECT: begin
          shift_q   <= r_shift;
          exp_adj_q <= r_exp;
          lr_q      <= r_lr;
          z_q       <= r_z;
          ov_q      <= r_ov;
          un_q      <= r_un;
        end
        ST_DONE: begin
          // Results and flags read as zero once back in IDLE.
          if (bus.ack_i) begin
            shift_q   <= '0;
            exp_adj_q <= '0;
            lr_q      <= 1'b0;
            z_q       <= 1'b0;
            ov_q      <= 1'b0;
            un_q      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o        = (state_q != ST_IDLE);
  assign bus.ready_o       = (state_q == ST_DONE);
  assign bus.Shift_Value_o = shift_q;
  assign bus.left_right_o  = lr_q;
  assign bus.Exp_adj_o     = exp_adj_q;
  assign bus.zero_flag_o   = z_q;
  assign bus.overflow_o    = ov_q;
  assign bus.underflow_o   = un_q;
  assign bus.state         = state_q;

endmodule
